// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
// Multicycle MIPS subset core (add, sub, and, or, nor, slt, addi, andi, ori,
// lw, sw, beq, bne, j, jal, jr) using one unified memory port for both
// instruction fetch and data access.
//
// Ports
//   clk           : sole clock, rising edge
//   reset         : active-low asynchronous reset
//   mem_req       : memory request (FETCH and MEMORY states only)
//   mem_we        : 1 = write, 0 = read
//   mem_addr      : byte address
//   mem_wdata     : store data
//   mem_rdata     : read data, sampled on the edge where mem_ready=1
//   mem_ready     : completes a transaction on an edge with mem_req=1
//   ALUResultOut  : ALUOut register
//   pc_out        : PC register
//   instr_done    : high on the last cycle of every instruction
//   illegal_instr : sticky, set by an unsupported opcode/funct
//   state_dbg     : current FSM state encoding
//
// Handshake: a transaction completes on a rising edge where mem_req=1 and
// mem_ready=1. While mem_req=1 and mem_ready=0, mem_addr/mem_we/mem_wdata are
// held. mem_ready is ignored whenever mem_req=0.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_INCREMENT = 32'd4,
    parameter logic [27:0] JUMP_MASK    = 28'h000_03FF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] ALUResultOut,
    output logic [31:0] pc_out,
    output logic        instr_done,
    output logic        illegal_instr,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT
    } alu_op_t;

    state_t      state, next_state;
    logic [31:0] pc, ir, a_reg, b_reg, alu_out, mdr;
    logic [31:0] rf [32];
    logic        illegal_q;

    // Instruction fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] imm_sext, imm_zext;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm      = ir[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};

    // Decode
    logic is_rtype, is_addi, is_andi, is_ori, is_lw, is_sw;
    logic is_beq, is_bne, is_j, is_jal, is_jr, is_illegal;

    always_comb begin
        is_rtype   = 1'b0;
        is_addi    = 1'b0;
        is_andi    = 1'b0;
        is_ori     = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        is_jal     = 1'b0;
        is_jr      = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A: is_rtype = 1'b1;
                    6'h08:   is_jr      = 1'b1;
                    default: is_illegal = 1'b1;
                endcase
            end
            6'h08:   is_addi    = 1'b1;
            6'h0C:   is_andi    = 1'b1;
            6'h0D:   is_ori     = 1'b1;
            6'h23:   is_lw      = 1'b1;
            6'h2B:   is_sw      = 1'b1;
            6'h04:   is_beq     = 1'b1;
            6'h05:   is_bne     = 1'b1;
            6'h02:   is_j       = 1'b1;
            6'h03:   is_jal     = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

    // ALU: operand B is the register for R-type, otherwise the extended
    // immediate (zero-extended only for the logical immediates).
    alu_op_t     alu_op;
    logic [31:0] alu_b, alu_res;
    logic        branch_taken;

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = imm_sext;
        if (is_rtype) begin
            alu_b = b_reg;
            case (funct)
                6'h22:   alu_op = ALU_SUB;
                6'h24:   alu_op = ALU_AND;
                6'h25:   alu_op = ALU_OR;
                6'h27:   alu_op = ALU_NOR;
                6'h2A:   alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end else if (is_andi) begin
            alu_op = ALU_AND;
            alu_b  = imm_zext;
        end else if (is_ori) begin
            alu_op = ALU_OR;
            alu_b  = imm_zext;
        end
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = a_reg + alu_b;
            ALU_SUB: alu_res = a_reg - alu_b;
            ALU_AND: alu_res = a_reg & alu_b;
            ALU_OR:  alu_res = a_reg | alu_b;
            ALU_NOR: alu_res = ~(a_reg | alu_b);
            ALU_SLT: alu_res = {31'h0, $signed(a_reg) < $signed(alu_b)};
            default: alu_res = '0;
        endcase
    end

    assign branch_taken = (is_beq && (a_reg == b_reg)) || (is_bne && (a_reg != b_reg));

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= next_state;
    end

    // FSM: next state
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:     if (mem_ready) next_state = S_DECODE;
            S_DECODE:    next_state = (is_j || is_jal || is_jr || is_illegal) ? S_FETCH : S_EXECUTE;
            S_EXECUTE: begin
                if (is_beq || is_bne)    next_state = S_FETCH;
                else if (is_lw || is_sw) next_state = S_MEMORY;
                else                     next_state = S_WRITEBACK;
            end
            S_MEMORY:    if (mem_ready) next_state = is_sw ? S_FETCH : S_WRITEBACK;
            S_WRITEBACK: next_state = S_FETCH;
            default:     next_state = S_FETCH;
        endcase
    end

    // FSM: outputs. The request is gated by reset so it drops the instant
    // reset is asserted, even in the middle of a wait.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc;
        mem_wdata  = b_reg;
        instr_done = 1'b0;
        case (state)
            S_FETCH:  mem_req = reset;
            S_MEMORY: begin
                mem_req  = reset;
                mem_we   = reset & is_sw;
                mem_addr = alu_out;
            end
            default: ;
        endcase
        instr_done = (state != S_FETCH) && (next_state == S_FETCH);
    end

    // Datapath
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    assign wb_dest = is_rtype ? rd : rt;
    assign wb_data = is_lw ? mdr : alu_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_VECTOR;
            ir        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= pc + PC_INCREMENT;
                    end
                end
                S_DECODE: begin
                    if (is_illegal) begin
                        illegal_q <= 1'b1;
                    end else begin
                        a_reg   <= rf[rs];
                        b_reg   <= rf[rt];
                        // Branch target computed speculatively from the
                        // already-incremented PC.
                        alu_out <= pc + {imm_sext[29:0], 2'b00};
                    end
                    if (is_j || is_jal) pc <= {pc[31:28], {ir[25:0], 2'b00} & JUMP_MASK};
                    if (is_jal)         rf[31] <= pc;
                    if (is_jr)          pc <= rf[rs];
                end
                S_EXECUTE: begin
                    if (is_beq || is_bne) begin
                        if (branch_taken) pc <= alu_out;
                    end else begin
                        alu_out <= alu_res;
                    end
                end
                S_MEMORY: begin
                    if (mem_ready && !is_sw) mdr <= mem_rdata;
                end
                S_WRITEBACK: begin
                    if (wb_dest != 5'd0) rf[wb_dest] <= wb_data;
                end
                default: ;
            endcase
        end
    end

    assign ALUResultOut  = alu_out;
    assign pc_out        = pc;
    assign illegal_instr = illegal_q;
    assign state_dbg     = state;

endmodule
